// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-RAM fetch/load-store arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arbState_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int MEM_ARB_MAX_LAT = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch port, load/store port and RAM port of mem_arbiter bundled together.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              mem_req;
  logic [3:0]        mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              stall;

  modport slave (
    input  if_req, if_addr, mem_req, mem_wen, mem_addr, mem_wdata, ram_rdata,
    output if_rdata, if_ready, mem_rdata, mem_ready,
           ram_en, ram_we, ram_addr, ram_wdata, stall
  );

  modport master (
    output if_req, if_addr, mem_req, mem_wen, mem_addr, mem_wdata, ram_rdata,
    input  if_rdata, if_ready, mem_rdata, mem_ready,
           ram_en, ram_we, ram_addr, ram_wdata, stall
  );
endinterface

// File: rtl/mem_arb_ibuf.sv
// One-entry fetch buffer for mem_arbiter; only built when MEM_ARB_IBUF_EN is defined.
module mem_arb_ibuf
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-3:0] lookupAddr,
  output logic              hit,
  output logic [DATA_W-1:0] hitData,
  input  logic              fill,
  input  logic [ADDR_W-3:0] fillAddr,
  input  logic [DATA_W-1:0] fillData,
  input  logic              inval,
  input  logic [ADDR_W-3:0] invalAddr
);
  logic              vld;
  logic [ADDR_W-3:0] tag;
  logic [DATA_W-1:0] data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld  <= 1'b0;
      tag  <= '0;
      data <= '0;
    end else if (fill) begin
      vld  <= 1'b1;
      tag  <= fillAddr;
      data <= fillData;
    end else if (inval && vld && (tag == invalAddr)) begin
      vld  <= 1'b0;
    end
  end

  assign hit     = vld && (tag == lookupAddr);
  assign hitData = data;
endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer sharing one single-port RAM between fetch and load/store.
// Optional one-entry fetch buffer under `define MEM_ARB_IBUF_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RAM_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);
  localparam int LAT_C = (RAM_LAT < 1) ? 1 :
                         (RAM_LAT > MEM_ARB_MAX_LAT) ? MEM_ARB_MAX_LAT : RAM_LAT;
  localparam logic [1:0] CNT_INIT = 2'(LAT_C - 1);

  arbState_t         state, stateNxt;
  owner_t            owner, lastOwner;
  logic [1:0]        cnt;
  logic [ADDR_W-1:0] ramAddr;
  logic [3:0]        ramWe;
  logic [DATA_W-1:0] ramWdata;
  logic              grantD, grantI, grant;
  logic              ibufHit, respI, respD;
  logic [DATA_W-1:0] respData;

  // Data wins a tie unless it also won the previous access.
  always_comb begin
    grantD = 1'b0;
    grantI = 1'b0;
    if (state == IDLE) begin
      if (bus.mem_req && bus.if_req) begin
        grantD = (lastOwner == OWN_I);
        grantI = (lastOwner == OWN_D);
      end else begin
        grantD = bus.mem_req;
        grantI = bus.if_req;
      end
    end
  end
  assign grant = grantD | grantI;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= OWN_D;
      lastOwner <= OWN_I;
      cnt       <= '0;
      ramAddr   <= '0;
      ramWe     <= '0;
      ramWdata  <= '0;
    end else begin
      state <= stateNxt;
      if (grant) begin
        owner    <= grantD ? OWN_D : OWN_I;
        ramAddr  <= {(grantD ? bus.mem_addr[ADDR_W-1:2] : bus.if_addr[ADDR_W-1:2]), 2'b00};
        ramWe    <= grantD ? bus.mem_wen : 4'b0000;
        ramWdata <= grantD ? bus.mem_wdata : '0;
      end
      if (state == ISSUE)     cnt <= CNT_INIT;
      else if (state == WAIT) cnt <= cnt - 2'd1;
      if (state == RESP)      lastOwner <= owner;
    end
  end

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (grant) stateNxt = (grantI && ibufHit) ? RESP : ISSUE;
      ISSUE:   stateNxt = (LAT_C == 1) ? RESP : WAIT;
      WAIT:    if (cnt == 2'd1) stateNxt = RESP;
      RESP:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

`ifdef MEM_ARB_IBUF_EN
  logic              fromBuf;
  logic [DATA_W-1:0] ibufData;

  // A buffered fetch skips ISSUE/WAIT; remember where its RESP data comes from.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       fromBuf <= 1'b0;
    else if (grant) fromBuf <= grantI && ibufHit;
  end

  mem_arb_ibuf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) uIbuf (
    .clk        (clk),
    .rst        (rst),
    .lookupAddr (bus.if_addr[ADDR_W-1:2]),
    .hit        (ibufHit),
    .hitData    (ibufData),
    .fill       (respI),
    .fillAddr   (ramAddr[ADDR_W-1:2]),
    .fillData   (respData),
    .inval      (grantD && (bus.mem_wen != 4'b0000)),
    .invalAddr  (bus.mem_addr[ADDR_W-1:2])
  );

  assign respData = fromBuf ? ibufData : bus.ram_rdata;
`else
  assign ibufHit  = 1'b0;
  assign respData = bus.ram_rdata;
`endif

  assign respI = (state == RESP) && (owner == OWN_I);
  assign respD = (state == RESP) && (owner == OWN_D);

  assign bus.ram_en    = (state == ISSUE);
  assign bus.ram_we    = ramWe;
  assign bus.ram_addr  = ramAddr;
  assign bus.ram_wdata = ramWdata;

  assign bus.if_ready  = respI;
  assign bus.if_rdata  = respI ? respData : '0;
  assign bus.mem_ready = respD;
  assign bus.mem_rdata = respD ? respData : '0;

  assign bus.stall = (bus.if_req & ~bus.if_ready) | (bus.mem_req & ~bus.mem_ready);
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter and sequencer sharing one single-port unified RAM between the pipeline's instruction-fetch port and its load/store port. It sits between the datapath and the memory, replacing separate instruction and data RAMs. Each access runs through a small FSM with a fixed RAM latency. A combinational `stall` tells the pipeline to freeze while either requester is waiting.

## Interface
Parameters:
- `ADDR_W`, 32, byte address width.
- `DATA_W`, 32, word width. Fixed at 32 because the byte mask is 4 bits.
- `RAM_LAT`, 1, cycles from `ram_en` sample to valid `ram_rdata`. Legal range 1..4.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  instruction fetch request; held until `if_ready`.
- `if_addr`  in  ADDR_W  fetch address; stable while `if_req` is high and `if_ready` is low.
- `if_rdata`  out  DATA_W  fetched word; valid only when `if_ready`.
- `if_ready`  out  1  one-cycle completion pulse for the fetch.
- `mem_req`  in  1  load/store request; held until `mem_ready`.
- `mem_wen`  in  4  byte write mask; 0 means load.
- `mem_addr`  in  ADDR_W  data address; stable under the same rule as `if_addr`.
- `mem_wdata`  in  DATA_W  store data.
- `mem_rdata`  out  DATA_W  load data; valid only when `mem_ready`.
- `mem_ready`  out  1  one-cycle completion pulse for the load/store.
- `ram_en`  out  1  RAM access strobe, one cycle per access.
- `ram_we`  out  4  byte write enables; qualified by `ram_en`.
- `ram_addr`  out  ADDR_W  word-aligned address; bits [1:0] forced to 0.
- `ram_wdata`  out  DATA_W  write data.
- `ram_rdata`  in  DATA_W  RAM read data, valid RAM_LAT cycles after `ram_en`.
- `stall`  out  1  pipeline freeze.

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Internal registers: `owner` (I or D), `last_owner`, and a latency counter `cnt` of 2 bits.
- IDLE, grant rule:
  - `mem_req` alone: grant D.
  - `if_req` alone: grant I.
  - Both requesting: grant D, unless `last_owner`==D, in which case grant I. Data wins, but the two sources strictly alternate under contention, so neither starves.
  - On a grant: latch address, mask and data into the `ram_*` registers, set `owner`, go to ISSUE.
- ISSUE: `ram_en`=1 for exactly this cycle. Load `cnt`=RAM_LAT-1.
  - If RAM_LAT==1, go to RESP.
  - Otherwise go to WAIT.
- WAIT: decrement `cnt`. Go to RESP when `cnt`==1.
- RESP:
  - Pulse the ready signal of `owner`, driving `ram_rdata` through to that port's rdata.
  - Update `last_owner` to `owner`, then return to IDLE.
  - Stores also complete here; the rdata output is don't-care for a store.
- `stall` = (`if_req` & ~`if_ready`) | (`mem_req` & ~`mem_ready`). It is combinational and independent of state.
- A new grant is never taken in RESP. The earliest next `ram_en` comes 2 cycles after a RESP.

## Timing
- Request sampled in IDLE at cycle 0:
  - `ram_en` asserted at cycle 1.
  - ready and rdata at cycle 1+RAM_LAT.
  - FSM back in IDLE at cycle 2+RAM_LAT.
- Per-access occupancy is RAM_LAT+2 cycles.
- Reset values: state IDLE, `owner`=D, `last_owner`=I.
  - `ram_en`, `ram_we`, `ram_addr`, `ram_wdata` all 0.
  - `if_ready`, `mem_ready` 0; `if_rdata`, `mem_rdata` 0.
- Reset mid-operation: the in-flight access is abandoned and no ready pulse is issued. A store whose `ram_en` was already sampled is not undone.
- Dropping a request before its ready pulse is illegal. Behaviour in that case is undefined; the bench flags it as an error.

## Configuration
- `MEM_ARB_IBUF_EN` defined: adds a one-entry fetch buffer {valid, addr[ADDR_W-1:2], data}.
  - Filled on every I RESP.
  - Hit = valid & addr match. A hit granted in IDLE goes straight to RESP, with no `ram_en` and data taken from the buffer; `if_ready` arrives at cycle 1.
  - Any D grant with nonzero `mem_wen` to the same word clears valid.
  - Reset clears valid.
- `MEM_ARB_IBUF_EN` undefined: no buffer, and every fetch uses the RAM.

## Structure
- Shared package `mem_arb_pkg` holds:
  - the state enum (IDLE/ISSUE/WAIT/RESP);
  - the owner encoding (I=1'b0, D=1'b1);
  - the constant `MEM_ARB_MAX_LAT`=4.
- Optional sub-module `mem_arb_ibuf` (fetch buffer), instantiated only under `MEM_ARB_IBUF_EN`. FSM and grant logic stay in `mem_arbiter`.

## Test plan
- Fetch, RAM_LAT=1: `if_req` with `if_addr`=0x0000_0040 at cycle 0 -> `ram_en` with `ram_addr`=0x40 at cycle 1; `if_ready` with the RAM word at cycle 2; `stall` high at cycles 0-1.
- Contention: `if_req` and load `mem_req` to 0x100 together at cycle 0 -> `mem_ready` at cycle 2; fetch `ram_en` at cycle 4; `if_ready` at cycle 5.
- Store, RAM_LAT=3: `mem_wen`=4'b0011, `mem_addr`=0x203, `mem_wdata`=0xDEAD_BEEF -> `ram_we`=0011 with `ram_addr`=0x200 at cycle 1; `mem_ready` at cycle 4.
- Alternation: both requests held continuously for 4 grants -> grant order D, I, D, I; no source waits more than one access.
- Reset: deassert `rst` in WAIT with RAM_LAT=3 -> all outputs 0 immediately; no ready pulse; the next request is served from IDLE normally.
- `MEM_ARB_IBUF_EN` only:
  - Re-fetch of 0x40 -> `if_ready` at cycle 1 with no `ram_en`.
  - Then store to 0x40, then fetch 0x40 -> full RAM access (`ram_en` asserted).
